// File: rtl/seg_txt_shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_txt_shifter_pkg
// Description : Shared frame geometry and FSM state encoding for the
//               segment-pattern serialiser.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_txt_shifter_pkg;

    localparam int SEG_DIGITS      = 8;
    localparam int SEG_FRAME_W     = SEG_DIGITS * 8;
    localparam int SEG_DIV_DEFAULT = 2;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_LATCH = 2'd2;

endpackage
`default_nettype wire

// File: rtl/seg_clk_div.sv
`default_nettype none
// ============================================================================
// Module      : seg_clk_div
// Description : Free-running divide-by-DIV counter with synchronous clear,
//               producing a one-cycle tick while enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_clk_div #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [7:0] c_LAST = 8'(DIV - 1);

    logic [7:0] r_cnt;

    assign tick = en && (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (clr) begin
            r_cnt <= 8'd0;
        end else if (en) begin
            r_cnt <= tick ? 8'd0 : r_cnt + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_txt_shifter.sv
`default_nettype none
// ============================================================================
// Module      : seg_txt_shifter
// Description : Snapshots a 64-bit segment pattern and shifts it MSB-first
//               into daisy-chained 74HC595-style registers, then latches.
//               Optional macro SEG_CHANGE_DETECT_EN auto-launches a frame
//               whenever the pattern differs from the last one shifted.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_txt_shifter
    import seg_txt_shifter_pkg::*;
#(
    parameter int DIV   = SEG_DIV_DEFAULT,
    parameter int WIDTH = SEG_FRAME_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] seg_txt,
    output logic             busy,
    output logic             done,
    output logic             seg_clk,
    output logic             seg_dout,
    output logic             seg_pen,
    output logic             seg_clrn
);

    localparam int c_CNT_W = $clog2(WIDTH);

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_shreg;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic               r_seg_clk;
    logic               r_pen;
    logic               r_done;
    logic               r_busy;
    logic               r_clrn;
    logic               r_lat_half;

    logic w_tick;
    logic w_launch;
    logic w_accept;
    logic w_lat_end;

`ifdef SEG_CHANGE_DETECT_EN
    logic [WIDTH-1:0] r_last;

    assign w_launch = start || (seg_txt != r_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= '0;
        end else if (w_accept) begin
            r_last <= seg_txt;
        end
    end
`else
    assign w_launch = start;
`endif

    assign w_accept  = (r_state == c_ST_IDLE) && w_launch;
    assign w_lat_end = (r_state == c_ST_LATCH) && w_tick && r_lat_half;

    // Divider keeps running through LATCH so the latch window is two ticks.
    seg_clk_div #(
        .DIV (DIV)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (r_state == c_ST_IDLE),
        .en    (r_state != c_ST_IDLE),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_seg_clk  <= 1'b0;
            r_pen      <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_clrn     <= 1'b0;
            r_lat_half <= 1'b0;
        end else begin
            r_clrn <= 1'b1;
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_busy <= 1'b0;
                    if (w_accept) begin
                        r_shreg   <= seg_txt;
                        r_bit_cnt <= '0;
                        r_seg_clk <= 1'b0;
                        r_state   <= c_ST_SHIFT;
                    end
                end
                c_ST_SHIFT: begin
                    r_busy <= 1'b1;
                    if (w_tick) begin
                        if (!r_seg_clk) begin
                            r_seg_clk <= 1'b1;
                        end else begin
                            r_seg_clk <= 1'b0;
                            r_shreg   <= r_shreg << 1;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (&r_bit_cnt) begin
                                r_state    <= c_ST_LATCH;
                                r_pen      <= 1'b1;
                                r_lat_half <= 1'b0;
                            end
                        end
                    end
                end
                c_ST_LATCH: begin
                    r_busy <= !w_lat_end;
                    if (w_tick) begin
                        if (r_lat_half) begin
                            r_pen   <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_lat_half <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign seg_clk  = r_seg_clk;
    assign seg_dout = r_shreg[WIDTH-1];
    assign seg_pen  = r_pen;
    assign seg_clrn = r_clrn;

endmodule
`default_nettype wire

// File: doc/seg_txt_shifter.md
# seg_txt_shifter

Parallel-to-serial stage that sits directly downstream of the hex-to-segment encoder. Snapshots the 64-bit segment pattern (8 digits × 8 segment bits) and shifts it out over a 3-wire serial link (clock, data, latch) into the board's daisy-chained 74HC595-style display shift registers. It then pulses the latch so all eight digits update at once, glitch-free. One frame per request; reports busy/done.

## Interface
Parameters:
- DIV, 2: seg_clk half-period in clk cycles; legal range 1..255.
- WIDTH, 64: frame length in bits; fixed to 8 × 8 segment bits.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: frame request; sampled every clk.
- seg_txt, input, 64: segment pattern from the encoder; byte [63:56] is the rightmost digit.
- busy, output, 1: high from the cycle after acceptance through the cycle before done.
- done, output, 1: one-cycle pulse at frame end.
- seg_clk, output, 1: serial shift clock to the display registers.
- seg_dout, output, 1: serial data, valid around each seg_clk rising edge.
- seg_pen, output, 1: latch/parallel-enable to the display registers; active high.
- seg_clrn, output, 1: clear to the display registers; active low.

## Operation
- Reset values: busy=0, done=0, seg_clk=0, seg_dout=0, seg_pen=0, seg_clrn=0.
- seg_clrn rises to 1 on the first clk edge after rst_n deasserts and stays 1.
- The FSM is IDLE → SHIFT → LATCH → IDLE.
- IDLE:
  - If start=1 on an edge: capture seg_txt into a 64-bit shift register, reset the divider and bit counter, present seg_dout=seg_txt[63], and go to SHIFT.
  - If start=0: hold. seg_dout holds its last value.
- SHIFT:
  - A divider produces a tick every DIV clk cycles.
  - A tick with seg_clk=0 raises seg_clk.
  - A tick with seg_clk=1 lowers seg_clk and shifts left, so seg_dout takes the next bit.
  - Bits go out MSB-first, seg_txt[63] down to seg_txt[0].
  - After the 64th falling edge, go to LATCH. The bit counter is 6 bits and the transition occurs at its wrap from 63.
- LATCH: seg_pen=1 for 2*DIV cycles, then go to IDLE and pulse done.
- start while busy is ignored, with no queueing.
- start on the same edge that done is asserted is ignored. start on the following cycle is accepted.
- seg_txt changing mid-frame has no effect; only the snapshot is shifted.
- rst_n asserted mid-frame: all outputs return to reset values immediately. The partial frame is discarded, and the display keeps its previous latched contents because seg_pen never pulses.

## Timing
- Acceptance edge = cycle 0.
- busy=1 from cycle 1.
- First seg_clk rise at cycle DIV. Each bit lasts 2*DIV cycles.
- seg_dout changes only on seg_clk falling edges, giving DIV cycles of setup and hold around each rising edge.
- 64th falling edge at cycle 128*DIV.
- seg_pen high on cycles 128*DIV .. 130*DIV-1.
- done=1 on cycle 130*DIV; busy=0 on the same cycle.
- Frame length: 260 cycles for DIV=2; 130 cycles for DIV=1.
- seg_clk and seg_pen are never high simultaneously.

## Configuration
- SEG_CHANGE_DETECT_EN defined:
  - A 64-bit register holds the last shifted frame, reset to 0.
  - In IDLE, a frame launches automatically whenever seg_txt differs from it, exactly as if start=1.
  - start still forces a frame.
  - The register updates at acceptance.
- Not defined: frames launch only on start. The comparison register and comparator are absent.

## Structure
- Shared package holds:
  - state enum {IDLE, SHIFT, LATCH};
  - SEG_FRAME_W=64, SEG_DIGITS=8, SEG_DIV_DEFAULT=2.
- One sub-module, seg_clk_div: a parameterised DIV counter with a synchronous clear and a one-cycle tick output.
- Everything else lives in seg_txt_shifter.

## Test plan
- Reset: hold rst_n=0 → all outputs 0. Release → seg_clrn=1 after one edge; busy, seg_clk, seg_pen remain 0.
- Single frame, DIV=2, seg_txt=64'h8000_0000_0000_0001:
  - Pulse start.
  - Bits sampled on seg_clk rising edges are 1, then 62 zeros, then 1.
  - Exactly 64 rising edges; seg_pen high for 4 cycles.
  - done on cycle 260; busy low on the same cycle.
- Snapshot and ignore:
  - Start with seg_txt=64'hFFFF_FFFF_FFFF_FFFF.
  - Change it to 0 and pulse start at cycle 50.
  - Received bits are all 1s and only one done occurs.
- Back-to-back, DIV=1:
  - start at cycle 0 and again on the cycle after done.
  - Two frames result with done at 130 and 261.
  - seg_clk never pulses during either seg_pen window.
- Mid-frame reset: assert rst_n=0 at cycle 100 → seg_clk=0, busy=0, seg_pen never pulses. After release, start → a normal full frame.
- With SEG_CHANGE_DETECT_EN:
  - Step seg_txt from 0 to 64'h1234_5678_9ABC_DEF0 with no start → one frame shifting that value.
  - Holding the value constant afterwards → no further frames.
